// File: rtl/player_action_ctrl_if.sv
// Signal bundle between a fighter's controller and its environment.
// SCEN is a one-clk frame strobe; outputs update on the clk after the SCEN edge.
interface player_action_ctrl_if;
    logic       SCEN;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic       atk1_sw;
    logic       atk2_sw;
    logic       attack_busy;
    logic       jump_active;
    logic       hit_in;
    logic [7:0] hit_dmg;

    logic       move_enable;
    logic       move_left;
    logic       move_right;
    logic       jump;
    logic       attack_enable;
    logic       attack1;
    logic       attack2;
    logic [7:0] health;
    logic       stunned;
    logic       ko;
    logic [2:0] state;

    modport master (
        output SCEN, btn_left, btn_right, btn_jump, atk1_sw, atk2_sw,
               attack_busy, jump_active, hit_in, hit_dmg,
        input  move_enable, move_left, move_right, jump, attack_enable,
               attack1, attack2, health, stunned, ko, state
    );

    modport slave (
        input  SCEN, btn_left, btn_right, btn_jump, atk1_sw, atk2_sw,
               attack_busy, jump_active, hit_in, hit_dmg,
        output move_enable, move_left, move_right, jump, attack_enable,
               attack1, attack2, health, stunned, ko, state
    );
endinterface

// File: rtl/player_action_ctrl.sv
// Per-fighter action sequencer: frame-rate FSM arbitrating hit > attack > move,
// single-shot attack commands, health tracking and KO.
module player_action_ctrl #(
    parameter logic [7:0] MAX_HEALTH     = 8'd100,
    parameter logic [7:0] HITSTUN_FRAMES = 8'd20,
    parameter logic [7:0] ATK_COOLDOWN   = 8'd8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    player_action_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ATTACK   = 3'd1,
        S_COOLDOWN = 3'd2,
        S_HITSTUN  = 3'd3,
        S_KO       = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_health, w_health_nxt, w_health_hit;
    logic [7:0] r_dmg, w_dmg;
    logic       r_sw1_q, r_sw2_q;
    logic       r_pend1, r_pend2, r_pend_hit;
    logic       w_pend1, w_pend2, w_pend_hit;
    logic       w_hit_take;
    logic       r_atk1, r_atk2, w_atk1_nxt, w_atk2_nxt;
    logic       w_en_nxt;
    logic       r_move_en, r_move_left, r_move_right, r_jump;
    logic       r_stunned, r_ko;

    // Pendings include an edge/hit arriving on the SCEN clk itself so none is lost.
    always_comb begin
        w_pend1      = r_pend1 | (bus.atk1_sw & ~r_sw1_q);
        w_pend2      = r_pend2 | (bus.atk2_sw & ~r_sw2_q);
        w_pend_hit   = r_pend_hit | bus.hit_in;
        w_dmg        = bus.hit_in ? bus.hit_dmg : r_dmg;
        w_health_hit = (w_dmg >= r_health) ? 8'd0 : (r_health - w_dmg);
        w_hit_take   = bus.SCEN && w_pend_hit &&
                       (r_state == S_IDLE || r_state == S_ATTACK || r_state == S_COOLDOWN);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_health_nxt = r_health;
        w_atk1_nxt   = r_atk1;
        w_atk2_nxt   = r_atk2;
        if (bus.SCEN) begin
            w_atk1_nxt = 1'b0;
            w_atk2_nxt = 1'b0;
        end
        if (w_hit_take) begin
            w_health_nxt = w_health_hit;
            if (w_health_hit == 8'd0) begin
                w_state_nxt = S_KO;
                w_cnt_nxt   = 8'd0;
            end else begin
                w_state_nxt = S_HITSTUN;
                w_cnt_nxt   = HITSTUN_FRAMES;
            end
        end else if (bus.SCEN) begin
            case (r_state)
                S_IDLE: begin
                    if ((w_pend1 || w_pend2) && !bus.jump_active) begin
                        w_atk1_nxt  = w_pend1;
                        w_atk2_nxt  = ~w_pend1;
                        w_state_nxt = S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (!bus.attack_busy) begin
                        if (ATK_COOLDOWN == 8'd0) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_COOLDOWN;
                            w_cnt_nxt   = ATK_COOLDOWN;
                        end
                    end
                end
                S_COOLDOWN, S_HITSTUN: begin
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_KO: begin
                    w_health_nxt = 8'd0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
        w_en_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ATTACK) ||
                   (w_state_nxt == S_COOLDOWN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_health     <= MAX_HEALTH;
            r_dmg        <= 8'd0;
            r_sw1_q      <= 1'b0;
            r_sw2_q      <= 1'b0;
            r_pend1      <= 1'b0;
            r_pend2      <= 1'b0;
            r_pend_hit   <= 1'b0;
            r_atk1       <= 1'b0;
            r_atk2       <= 1'b0;
            r_move_en    <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_jump       <= 1'b0;
            r_stunned    <= 1'b0;
            r_ko         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_health     <= w_health_nxt;
            r_dmg        <= w_dmg;
            r_sw1_q      <= bus.atk1_sw;
            r_sw2_q      <= bus.atk2_sw;
            // Every SCEN consumes or discards whatever was pending this frame.
            r_pend1      <= w_pend1 & ~bus.SCEN;
            r_pend2      <= w_pend2 & ~bus.SCEN;
            r_pend_hit   <= w_pend_hit & ~bus.SCEN;
            r_atk1       <= w_atk1_nxt;
            r_atk2       <= w_atk2_nxt;
            r_move_en    <= w_en_nxt;
            r_move_left  <= bus.btn_left & ~bus.btn_right & w_en_nxt;
            r_move_right <= bus.btn_right & ~bus.btn_left & w_en_nxt;
            r_jump       <= bus.btn_jump & w_en_nxt;
            r_stunned    <= (w_state_nxt == S_HITSTUN);
            r_ko         <= (w_state_nxt == S_KO);
        end
    end

    assign bus.state         = r_state;
    assign bus.health        = r_health;
    assign bus.move_enable   = r_move_en;
    assign bus.attack_enable = r_move_en;
    assign bus.move_left     = r_move_left;
    assign bus.move_right    = r_move_right;
    assign bus.jump          = r_jump;
    assign bus.attack1       = r_atk1;
    assign bus.attack2       = r_atk2;
    assign bus.stunned       = r_stunned;
    assign bus.ko            = r_ko;

endmodule
